control_unit_seq: RTL
=====================

Name: control_unit_seq

Overview:
Sequential successor to the ID-stage control decoder. It decodes mode/opcode/S into the EX-stage control bundle and registers that bundle as the ID/EX control register. A small FSM handles three things: hazard bubbles, multi-cycle memory accesses with a ready/timeout handshake, and post-branch flush cycles. It sits between the ID stage and EX. Its stall/flush outputs drive the IF/ID freeze and flush.

Parameters:
MODE_LEN, 2, width of instruction mode field
OPCODE_LEN, 4, width of opcode field
EXE_CMD_LEN, 4, width of EX command
MEM_TIMEOUT, 15, max MEM_WAIT cycles before abort (>=1)
FLUSH_CYCLES, 1, bubble cycles issued after a taken branch (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  ID holds a valid instruction
mode  in  MODE_LEN  instruction mode field
opcode  in  OPCODE_LEN  data-processing opcode
s  in  1  S bit (for memory mode: 1=LDR, 0=STR)
imm_in  in  1  I bit from instruction
cond_pass  in  1  condition check result for current instruction
hazard  in  1  data hazard detected by hazard unit
mem_ready  in  1  memory controller completes access
ex_valid  out  1  registered: bundle is a real instruction
exe_cmd  out  EXE_CMD_LEN  registered EX command
mem_read  out  1  registered
mem_write  out  1  registered
wb_enable  out  1  registered
imm  out  1  registered copy of imm_in
branch_taken  out  1  registered
status_write_enable  out  1  registered
mem_req  out  1  combinational: high in MEM_WAIT
stall  out  1  combinational: freeze PC and IF/ID
flush  out  1  combinational: flush IF/ID
illegal  out  1  registered one-cycle pulse on undecodable instruction
mem_error  out  1  sticky, set on timeout, cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=RUN, counters=0, every registered output=0. mem_req, stall and flush are 0 in RUN.
- Decode. Mode 00 is arithmetic: wb_enable=1, status_write_enable=s, with this mapping:
  - MOV 1101->0001; MVN 1111->1001; ADD 0100->0010; ADC 0101->0011; SUB 0010->0100; SBC 0110->0101
  - AND 0000->0110; ORR 1100->0111; EOR 0001->1000
  - CMP 1010->0100 and TST 1000->0110, each with wb_enable=0 and status_write_enable=1
- Any other arithmetic opcode is illegal.
- Mode 01 is memory, exe_cmd=0010, status_write_enable=0. LDR: mem_read=1, wb_enable=1. STR: mem_write=1.
- Mode 10 is branch: branch_taken=1, all other controls 0. Mode 11 is illegal.
- Bubble: all registered control outputs and ex_valid are 0.
- State RUN, with priorities checked in order each cycle:
  - valid_in=0 -> bubble.
  - hazard=1 -> bubble, stall=1.
  - cond_pass=0 -> bubble, no stall.
  - illegal -> bubble, illegal=1 next cycle.
  - Otherwise register the decoded bundle with ex_valid=1.
  - If the bundle is memory -> MEM_WAIT, counter=0.
  - If the bundle is branch -> FLUSH, counter=FLUSH_CYCLES-1.
- State MEM_WAIT:
  - Registered bundle is held unchanged. mem_req=1, stall=1. Counter increments.
  - mem_ready=1 -> RUN next edge. The bundle becomes a bubble on that edge unless a new instruction is accepted under the RUN rules the following cycle.
  - If mem_ready=1 in the same cycle that counter==MEM_TIMEOUT-1, ready wins.
  - Counter reaches MEM_TIMEOUT-1 without ready -> set mem_error, return to RUN, bubble.
  - hazard and valid_in are ignored while in MEM_WAIT.
- State FLUSH:
  - Registered outputs are a bubble. flush=1, stall=0.
  - Counter decrements; when counter==0 -> RUN.
  - Instructions presented during FLUSH are discarded.
- mem_ready asserted in RUN or FLUSH is ignored.
- Reset mid-MEM_WAIT or mid-FLUSH returns to RUN immediately and drops mem_req.
- Latency: one cycle from ID inputs to registered outputs. stall, flush and mem_req have zero-cycle latency from state.

Decomposition:
- Shared package arm_ctrl_pkg holds:
  - mode encodings (ARITH, MEMORY, BRANCH)
  - opcode constants and EXE command constants
  - S_LDR/S_STR
  - FSM state enum (RUN, MEM_WAIT, FLUSH)
  - a ctrl_bundle struct (exe_cmd, mem_read, mem_write, wb_enable, imm, branch_taken, status_write_enable)
- One combinational sub-module, ctrl_decode: mode/opcode/s -> bundle + illegal flag. The FSM and registers stay in the top module.

Test Plan:
- Reset mid-operation: rst_n low while in MEM_WAIT -> all outputs 0 immediately, mem_req=0, mem_error keeps 0 if never set.
- ADDS, then CMP (valid, cond_pass=1, no hazard): after 1 cycle, ADDS gives exe_cmd=0010, wb_enable=1, status_write_enable=1; next cycle, CMP gives exe_cmd=0100, wb_enable=0, status_write_enable=1. opcode 0011 in mode 00 -> bubble with an illegal pulse.
- Hazard and condition: hazard=1 for 2 cycles -> stall=1 for those 2 cycles and 2 bubbles; then the instruction issues. cond_pass=0 -> bubble with stall=0.
- LDR with mem_ready after 3 cycles:
  - mem_read=1 and wb_enable=1 held.
  - mem_req=1 and stall=1 for 3 cycles.
  - Returns to RUN; mem_error=0.
- STR with mem_ready never asserted, MEM_TIMEOUT=15: mem_req is high 15 cycles, then mem_error=1 sticky and mem_write drops. Also check mem_ready on the final counter cycle -> completes without error.
- Branch with FLUSH_CYCLES=2: branch_taken=1 for one cycle, then flush=1 for 2 cycles. Instructions in those cycles are dropped (ex_valid=0). Stray mem_ready in RUN changes nothing.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ID/EX control path: field widths, opcode and
// EX command encodings, the control FSM states and the EX control bundle.
package arm_ctrl_pkg;

   localparam int MODE_LEN    = 2;
   localparam int OPCODE_LEN  = 4;
   localparam int EXE_CMD_LEN = 4;

   localparam logic [MODE_LEN-1:0] MODE_ARITH  = 2'b00;
   localparam logic [MODE_LEN-1:0] MODE_MEMORY = 2'b01;
   localparam logic [MODE_LEN-1:0] MODE_BRANCH = 2'b10;

   localparam logic [OPCODE_LEN-1:0] OP_AND = 4'b0000;
   localparam logic [OPCODE_LEN-1:0] OP_EOR = 4'b0001;
   localparam logic [OPCODE_LEN-1:0] OP_SUB = 4'b0010;
   localparam logic [OPCODE_LEN-1:0] OP_ADD = 4'b0100;
   localparam logic [OPCODE_LEN-1:0] OP_ADC = 4'b0101;
   localparam logic [OPCODE_LEN-1:0] OP_SBC = 4'b0110;
   localparam logic [OPCODE_LEN-1:0] OP_TST = 4'b1000;
   localparam logic [OPCODE_LEN-1:0] OP_CMP = 4'b1010;
   localparam logic [OPCODE_LEN-1:0] OP_ORR = 4'b1100;
   localparam logic [OPCODE_LEN-1:0] OP_MOV = 4'b1101;
   localparam logic [OPCODE_LEN-1:0] OP_MVN = 4'b1111;

   localparam logic [EXE_CMD_LEN-1:0] EXE_MOV = 4'b0001;
   localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'b0010;
   localparam logic [EXE_CMD_LEN-1:0] EXE_ADC = 4'b0011;
   localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'b0100;
   localparam logic [EXE_CMD_LEN-1:0] EXE_SBC = 4'b0101;
   localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'b0110;
   localparam logic [EXE_CMD_LEN-1:0] EXE_ORR = 4'b0111;
   localparam logic [EXE_CMD_LEN-1:0] EXE_EOR = 4'b1000;
   localparam logic [EXE_CMD_LEN-1:0] EXE_MVN = 4'b1001;

   localparam logic S_LDR = 1'b1;
   localparam logic S_STR = 1'b0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } cu_state_e;

   typedef struct packed {
      logic [EXE_CMD_LEN-1:0] exe_cmd;
      logic                   mem_read;
      logic                   mem_write;
      logic                   wb_enable;
      logic                   imm;
      logic                   branch_taken;
      logic                   status_write_enable;
   } ctrl_bundle_t;

endpackage

// File: rtl/control_unit_seq_if.sv
// ID-stage to control-unit bundle: instruction fields and hazard/condition inputs in,
// ID/EX control register, pipeline stall/flush and memory handshake out.
interface control_unit_seq_if;
   import arm_ctrl_pkg::*;

   logic                   valid_in;
   logic [MODE_LEN-1:0]    mode;
   logic [OPCODE_LEN-1:0]  opcode;
   logic                   s;
   logic                   imm_in;
   logic                   cond_pass;
   logic                   hazard;
   // mem_req stays high while an access is outstanding; the access completes on the
   // rising edge of any cycle that sees mem_req && mem_ready. mem_ready alone means nothing.
   logic                   mem_ready;
   logic                   mem_req;

   logic                   ex_valid;
   logic [EXE_CMD_LEN-1:0] exe_cmd;
   logic                   mem_read;
   logic                   mem_write;
   logic                   wb_enable;
   logic                   imm;
   logic                   branch_taken;
   logic                   status_write_enable;
   logic                   stall;
   logic                   flush;
   logic                   illegal;
   logic                   mem_error;
   cu_state_e              dbg_state;

   modport slave (
      input  valid_in, mode, opcode, s, imm_in, cond_pass, hazard, mem_ready,
      output ex_valid, exe_cmd, mem_read, mem_write, wb_enable, imm, branch_taken,
             status_write_enable, mem_req, stall, flush, illegal, mem_error, dbg_state
   );

   modport master (
      output valid_in, mode, opcode, s, imm_in, cond_pass, hazard, mem_ready,
      input  ex_valid, exe_cmd, mem_read, mem_write, wb_enable, imm, branch_taken,
             status_write_enable, mem_req, stall, flush, illegal, mem_error, dbg_state
   );

endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational decode of mode/opcode/S into the EX control bundle, flagging
// encodings that have no meaning (unused arithmetic opcodes and mode 11).
module ctrl_decode
   import arm_ctrl_pkg::*;
(
   input  logic [MODE_LEN-1:0]   mode,
   input  logic [OPCODE_LEN-1:0] opcode,
   input  logic                  s,
   input  logic                  imm_in,
   output ctrl_bundle_t          bundle,
   output logic                  illegal
);

   always_comb begin
      bundle  = '0;
      illegal = 1'b0;
      case (mode)
         MODE_ARITH: begin
            bundle.wb_enable           = 1'b1;
            bundle.status_write_enable = s;
            bundle.imm                 = imm_in;
            case (opcode)
               OP_MOV: bundle.exe_cmd = EXE_MOV;
               OP_MVN: bundle.exe_cmd = EXE_MVN;
               OP_ADD: bundle.exe_cmd = EXE_ADD;
               OP_ADC: bundle.exe_cmd = EXE_ADC;
               OP_SUB: bundle.exe_cmd = EXE_SUB;
               OP_SBC: bundle.exe_cmd = EXE_SBC;
               OP_AND: bundle.exe_cmd = EXE_AND;
               OP_ORR: bundle.exe_cmd = EXE_ORR;
               OP_EOR: bundle.exe_cmd = EXE_EOR;
               // Compare/test only update flags, whatever S says.
               OP_CMP: begin
                  bundle.exe_cmd             = EXE_SUB;
                  bundle.wb_enable           = 1'b0;
                  bundle.status_write_enable = 1'b1;
               end
               OP_TST: begin
                  bundle.exe_cmd             = EXE_AND;
                  bundle.wb_enable           = 1'b0;
                  bundle.status_write_enable = 1'b1;
               end
               default: begin
                  bundle  = '0;
                  illegal = 1'b1;
               end
            endcase
         end
         MODE_MEMORY: begin
            bundle.exe_cmd   = EXE_ADD;
            bundle.imm       = imm_in;
            bundle.mem_read  = (s == S_LDR);
            bundle.wb_enable = (s == S_LDR);
            bundle.mem_write = (s == S_STR);
         end
         MODE_BRANCH: bundle.branch_taken = 1'b1;
         default:     illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit_seq.sv
// ID/EX control register with a RUN / MEM_WAIT / FLUSH sequencer that inserts hazard
// bubbles, holds memory operations until ready or timeout, and flushes after branches.
module control_unit_seq
   import arm_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 15,
   parameter int FLUSH_CYCLES = 1
) (
   input logic               clk,
   input logic               rst_n,
   control_unit_seq_if.slave bus
);

   localparam int CNT_MAX = (MEM_TIMEOUT > FLUSH_CYCLES) ? MEM_TIMEOUT : FLUSH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   cu_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   ctrl_bundle_t       bundle_q, bundle_d;
   logic               ex_valid_q, ex_valid_d;
   logic               illegal_q, illegal_d;
   logic               mem_error_q, mem_error_d;

   ctrl_bundle_t       dec_bundle;
   logic               dec_illegal;
   logic               issue_ok;

   ctrl_decode u_decode (
      .mode    (bus.mode),
      .opcode  (bus.opcode),
      .s       (bus.s),
      .imm_in  (bus.imm_in),
      .bundle  (dec_bundle),
      .illegal (dec_illegal)
   );

   assign issue_ok = bus.valid_in && !bus.hazard && bus.cond_pass;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bundle_d    = bundle_q;
      ex_valid_d  = ex_valid_q;
      illegal_d   = 1'b0;
      mem_error_d = mem_error_q;
      case (state_q)
         RUN: begin
            bundle_d   = '0;
            ex_valid_d = 1'b0;
            if (issue_ok) begin
               if (dec_illegal) begin
                  illegal_d = 1'b1;
               end else begin
                  bundle_d   = dec_bundle;
                  ex_valid_d = 1'b1;
                  if (dec_bundle.mem_read || dec_bundle.mem_write) begin
                     state_d = MEM_WAIT;
                     cnt_d   = '0;
                  end else if (dec_bundle.branch_taken) begin
                     state_d = FLUSH;
                     cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                  end
               end
            end
         end
         MEM_WAIT: begin
            // Ready is checked first so a ready on the last allowed cycle still completes.
            if (bus.mem_ready || (cnt_q == CNT_W'(MEM_TIMEOUT - 1))) begin
               if (!bus.mem_ready) mem_error_d = 1'b1;
               state_d    = RUN;
               cnt_d      = '0;
               bundle_d   = '0;
               ex_valid_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FLUSH: begin
            bundle_d   = '0;
            ex_valid_d = 1'b0;
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: begin
            state_d    = RUN;
            cnt_d      = '0;
            bundle_d   = '0;
            ex_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         bundle_q    <= '0;
         ex_valid_q  <= 1'b0;
         illegal_q   <= 1'b0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bundle_q    <= bundle_d;
         ex_valid_q  <= ex_valid_d;
         illegal_q   <= illegal_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign bus.ex_valid            = ex_valid_q;
   assign bus.exe_cmd             = bundle_q.exe_cmd;
   assign bus.mem_read            = bundle_q.mem_read;
   assign bus.mem_write           = bundle_q.mem_write;
   assign bus.wb_enable           = bundle_q.wb_enable;
   assign bus.imm                 = bundle_q.imm;
   assign bus.branch_taken        = bundle_q.branch_taken;
   assign bus.status_write_enable = bundle_q.status_write_enable;
   assign bus.illegal             = illegal_q;
   assign bus.mem_error           = mem_error_q;
   assign bus.dbg_state           = state_q;

   // A hazard only stalls when there is an instruction to hold back.
   assign bus.mem_req = (state_q == MEM_WAIT);
   assign bus.stall   = (state_q == MEM_WAIT) ||
                        ((state_q == RUN) && bus.valid_in && bus.hazard);
   assign bus.flush   = (state_q == FLUSH);

endmodule
